// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU front-end arbiter: op codes, controller states, flag layout.
package fpu_pkg;

   localparam logic [1:0] ADD = 2'b00;
   localparam logic [1:0] SUB = 2'b01;
   localparam logic [1:0] MUL = 2'b10;
   localparam logic [1:0] DIV = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10,
      ST_RESP = 2'b11
   } state_t;

   localparam int FLG_ZERO = 0;
   localparam int FLG_OVF  = 1;
   localparam int FLG_UNF  = 2;
   localparam int FLG_NAN  = 3;
   localparam int FLG_ERR  = 4;

   // Canned flag words for responses the FPU never produces itself
   localparam logic [4:0] FLAGS_DIV = 5'((1 << FLG_ERR) | (1 << FLG_NAN));
   localparam logic [4:0] FLAGS_TMO = 5'(1 << FLG_ERR);

endpackage

// File: rtl/fpu_rr_arb2.sv
// Two-way round-robin grant; the pointer moves only when a grant is actually taken.
module fpu_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid0,
   input  logic       valid1,
   input  logic       advance,
   output logic [1:0] grant
);

   logic r_prio1;

   always_comb begin
      grant = 2'b00;
      if (valid0 && (!valid1 || !r_prio1)) grant = 2'b01;
      else if (valid1)                     grant = 2'b10;
   end

   always_ff @(posedge clk) begin
      if (rst)          r_prio1 <= 1'b0;
      else if (advance) r_prio1 <= grant[0];
   end

endmodule

// File: rtl/fpu_arbiter.sv
// Two-requester front end for a single FPU: round-robin grant, load/run/done sequencing, tagged response.
// Optional run-length abort guarded by FPU_ARB_TIMEOUT_EN.
module fpu_arbiter
   import fpu_pkg::*;
#(
   parameter int Mantissa_Size  = 23,
   parameter int Exponent_Size  = 8,
   parameter int N              = Mantissa_Size + Exponent_Size,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [1:0]   req0_op,
   input  logic [N:0]   req0_a,
   input  logic [N:0]   req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [1:0]   req1_op,
   input  logic [N:0]   req1_a,
   input  logic [N:0]   req1_b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [N:0]   rsp_result,
   output logic [4:0]   rsp_flags,
   output logic         fpu_load,
   output logic         fpu_enable,
   output logic [1:0]   fpu_op,
   output logic [N:0]   fpu_a,
   output logic [N:0]   fpu_b,
   input  logic         fpu_done,
   input  logic [N:0]   fpu_result,
   input  logic         fpu_zero,
   input  logic         fpu_overflow,
   input  logic         fpu_underflow,
   input  logic         fpu_NAN
);

   state_t       r_state, w_next;
   logic [1:0]   w_grant;
   logic         w_idle, w_accept, w_sel, w_done_ok, w_tmo_hit;
   logic [1:0]   w_op;
   logic [4:0]   w_fpu_flags;
   logic         r_first, r_id;
   logic [1:0]   r_op;
   logic [N:0]   r_a, r_b, r_result;
   logic [4:0]   r_flags;

   // Grants are only offered in IDLE and never while reset is held
   assign w_idle   = (r_state == ST_IDLE) && !rst;
   assign w_accept = w_idle && (w_grant != 2'b00);
   assign w_sel    = w_grant[1];
   assign w_op     = w_sel ? req1_op : req0_op;

   fpu_rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .valid0  (req0_valid),
      .valid1  (req1_valid),
      .advance (w_accept),
      .grant   (w_grant)
   );

   assign req0_ready = w_idle && w_grant[0];
   assign req1_ready = w_idle && w_grant[1];

   // The first RUN cycle may still see a done left over from a previous operation
   assign w_done_ok = (r_state == ST_RUN) && !r_first && fpu_done;

`ifdef FPU_ARB_TIMEOUT_EN
   localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] r_tmo;

   always_ff @(posedge clk) begin
      if (rst)                     r_tmo <= '0;
      else if (r_state == ST_LOAD) r_tmo <= '0;
      else if (r_state == ST_RUN)  r_tmo <= r_tmo + TW'(1);
   end

   assign w_tmo_hit = (r_state == ST_RUN) && !w_done_ok && (r_tmo == TMO_LAST);
`else
   assign w_tmo_hit = 1'b0;
`endif

   always_comb begin
      w_fpu_flags           = '0;
      w_fpu_flags[FLG_ZERO] = fpu_zero;
      w_fpu_flags[FLG_OVF]  = fpu_overflow;
      w_fpu_flags[FLG_UNF]  = fpu_underflow;
      w_fpu_flags[FLG_NAN]  = fpu_NAN;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = (w_op == DIV) ? ST_RESP : ST_LOAD;
         ST_LOAD: w_next = ST_RUN;
         ST_RUN:  if (w_done_ok || w_tmo_hit) w_next = ST_RESP;
         ST_RESP: if (rsp_ready) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      fpu_load   = (r_state == ST_LOAD);
      fpu_enable = (r_state == ST_RUN);
      rsp_valid  = (r_state == ST_RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_id     <= 1'b0;
         r_first  <= 1'b0;
         r_result <= '0;
         r_flags  <= '0;
      end else begin
         if (w_accept) begin
            r_op <= w_op;
            r_a  <= w_sel ? req1_a : req0_a;
            r_b  <= w_sel ? req1_b : req0_b;
            r_id <= w_sel;
            if (w_op == DIV) begin
               r_result <= '0;
               r_flags  <= FLAGS_DIV;
            end
         end
         if (r_state == ST_LOAD)     r_first <= 1'b1;
         else if (r_state == ST_RUN) r_first <= 1'b0;
         if (w_done_ok) begin
            r_result <= fpu_result;
            r_flags  <= w_fpu_flags;
         end else if (w_tmo_hit) begin
            r_result <= '0;
            r_flags  <= FLAGS_TMO;
         end
      end
   end

   assign fpu_op     = r_op;
   assign fpu_a      = r_a;
   assign fpu_b      = r_b;
   assign rsp_id     = r_id;
   assign rsp_result = r_result;
   assign rsp_flags  = r_flags;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a cycle-stepped FPU model; inputs driven and outputs sampled on negedge.
module tb_fpu_arbiter;

`ifdef FPU_ARB_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 64;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [1:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [31:0] rsp_result;
   logic [4:0]  rsp_flags;
   logic        fpu_load, fpu_enable, fpu_done;
   logic [1:0]  fpu_op;
   logic [31:0] fpu_a, fpu_b, fpu_result;
   logic        fpu_zero, fpu_overflow, fpu_underflow, fpu_NAN;

   int          n_pass = 0;
   int          n_checks = 0;

   // FPU model state
   logic        m_manual = 1'b0;
   logic        m_armed = 1'b0;
   int          m_cnt = 0;
   int          m_delay = 2;
   logic [31:0] m_result = '0;
   logic [3:0]  m_flags = '0;

   always #5 clk = ~clk;

   fpu_arbiter #(.Mantissa_Size(23), .Exponent_Size(8), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .fpu_load(fpu_load), .fpu_enable(fpu_enable), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
      .fpu_done(fpu_done), .fpu_result(fpu_result), .fpu_zero(fpu_zero), .fpu_overflow(fpu_overflow),
      .fpu_underflow(fpu_underflow), .fpu_NAN(fpu_NAN)
   );

   // Advance one cycle; the model raises done m_delay cycles after the load strobe
   task automatic tick();
      @(negedge clk);
      if (!m_manual) begin
         if (fpu_load) begin
            m_cnt   = 0;
            m_armed = 1'b1;
         end else if (m_armed && fpu_enable) begin
            m_cnt++;
         end else begin
            m_armed = 1'b0;
         end
         fpu_done   = m_armed && !fpu_load && (m_cnt >= m_delay);
         fpu_result = m_result;
         {fpu_NAN, fpu_underflow, fpu_overflow, fpu_zero} = m_flags;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      req0_op = 2'b00; req1_op = 2'b00;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      fpu_done = 1'b0; fpu_result = '0;
      fpu_zero = 1'b0; fpu_overflow = 1'b0; fpu_underflow = 1'b0; fpu_NAN = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_flags, fpu_load, fpu_enable, fpu_op, fpu_a, fpu_b,
           req0_ready, req1_ready} !== '0)
         $display("FAIL reset_outputs: rsp_v=%b id=%b res=%h flg=%b load=%b en=%b op=%b a=%h b=%h, need all 0",
                  rsp_valid, rsp_id, rsp_result, rsp_flags, fpu_load, fpu_enable, fpu_op, fpu_a, fpu_b);
      else n_pass++;
      req0_valid = 1'b1; req0_op = 2'b10; req0_a = 32'h40000000; req0_b = 32'h40400000;
      req1_valid = 1'b1; req1_op = 2'b10; req1_a = 32'h40800000; req1_b = 32'h3F000000;
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b00)
         $display("FAIL reset_ready: got %b, need 00", {req0_ready, req1_ready});
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_rr_mul();
      int lat;
      logic r1_seen;
      m_delay = 2; m_result = 32'h40C00000; m_flags = 4'b0000;
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b10)
         $display("FAIL rr_first_grant: got %b, need 10", {req0_ready, req1_ready});
      else n_pass++;
      tick();
      req0_valid = 1'b0;
      lat = 1;
      n_checks++;
      if ({fpu_load, fpu_op, fpu_a, fpu_b} !== {1'b1, 2'b10, 32'h40000000, 32'h40400000})
         $display("FAIL rr_load0: load=%b op=%b a=%h b=%h, need 1 10 40000000 40400000",
                  fpu_load, fpu_op, fpu_a, fpu_b);
      else n_pass++;
      r1_seen = 1'b0;
      while (!rsp_valid && lat < 20) begin
         if (req1_ready) r1_seen = 1'b1;
         tick();
         lat++;
      end
      if (req1_ready) r1_seen = 1'b1;
      n_checks++;
      if (r1_seen !== 1'b0) $display("FAIL rr_req1_held: req1_ready rose before IDLE, need 0");
      else n_pass++;
      n_checks++;
      if (lat !== 4) $display("FAIL rr_latency: got %0d cycles, need 4", lat);
      else n_pass++;
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 1'b0, 32'h40C00000, 5'b00000})
         $display("FAIL rr_rsp0: v=%b id=%b res=%h flg=%b, need 1 0 40c00000 00000",
                  rsp_valid, rsp_id, rsp_result, rsp_flags);
      else n_pass++;
      m_result = 32'h40000000;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_checks++;
      if ({rsp_valid, req0_ready, req1_ready} !== 3'b001)
         $display("FAIL rr_second_grant: v/r0/r1=%b, need 001", {rsp_valid, req0_ready, req1_ready});
      else n_pass++;
      tick();
      req1_valid = 1'b0;
      lat = 1;
      n_checks++;
      if ({fpu_load, fpu_a, fpu_b} !== {1'b1, 32'h40800000, 32'h3F000000})
         $display("FAIL rr_load1: load=%b a=%h b=%h, need 1 40800000 3f000000", fpu_load, fpu_a, fpu_b);
      else n_pass++;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'h40000000})
         $display("FAIL rr_rsp1: v=%b id=%b res=%h, need 1 1 40000000", rsp_valid, rsp_id, rsp_result);
      else n_pass++;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_add();
      int lat, loads, ens;
      m_delay = 5; m_result = 32'h40400000; m_flags = 4'b0000;
      req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'h3F800000; req0_b = 32'h40000000;
      #1;
      n_checks++;
      if (req0_ready !== 1'b1) $display("FAIL add_ready: got %b, need 1", req0_ready);
      else n_pass++;
      tick();
      req0_valid = 1'b0;
      lat = 1; loads = int'(fpu_load); ens = int'(fpu_enable);
      n_checks++;
      if ({fpu_op, fpu_a, fpu_b} !== {2'b00, 32'h3F800000, 32'h40000000})
         $display("FAIL add_operands: op=%b a=%h b=%h, need 00 3f800000 40000000", fpu_op, fpu_a, fpu_b);
      else n_pass++;
      while (!rsp_valid && lat < 30) begin
         tick();
         lat++;
         loads += int'(fpu_load);
         ens   += int'(fpu_enable);
      end
      n_checks++;
      if (loads !== 1 || ens !== 5 || lat !== 7)
         $display("FAIL add_sequence: loads=%0d enables=%0d latency=%0d, need 1 5 7", loads, ens, lat);
      else n_pass++;
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 1'b0, 32'h40400000, 5'b00000})
         $display("FAIL add_rsp: v=%b id=%b res=%h flg=%b, need 1 0 40400000 00000",
                  rsp_valid, rsp_id, rsp_result, rsp_flags);
      else n_pass++;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_div();
      req1_valid = 1'b1; req1_op = 2'b11; req1_a = 32'h40000000; req1_b = 32'h00000000;
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b01)
         $display("FAIL div_ready: got %b, need 01", {req0_ready, req1_ready});
      else n_pass++;
      tick();
      req1_valid = 1'b0;
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_flags, fpu_load, fpu_enable} !==
          {1'b1, 1'b1, 32'h00000000, 5'b11000, 1'b0, 1'b0})
         $display("FAIL div_rsp: v=%b id=%b res=%h flg=%b load=%b en=%b, need 1 1 00000000 11000 0 0",
                  rsp_valid, rsp_id, rsp_result, rsp_flags, fpu_load, fpu_enable);
      else n_pass++;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_checks++;
      if ({rsp_valid, fpu_load} !== 2'b00)
         $display("FAIL div_after: v=%b load=%b, need 0 0", rsp_valid, fpu_load);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int lat;
      m_delay = 2; m_result = 32'h40C00000; m_flags = 4'b0101;
      req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'h40A00000; req0_b = 32'h3F800000;
      tick();
      req0_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      req0_valid = 1'b1;
      req1_valid = 1'b1; req1_op = 2'b11;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) rsp_ready = 1'b1;
         #1;
         n_checks++;
         if ({rsp_valid, rsp_id, rsp_result, rsp_flags, req0_ready, req1_ready} !==
             {1'b1, 1'b0, 32'h40C00000, 5'b00101, 1'b0, 1'b0})
            $display("FAIL bp_hold[%0d]: v=%b id=%b res=%h flg=%b r0=%b r1=%b, need 1 0 40c00000 00101 0 0",
                     i, rsp_valid, rsp_id, rsp_result, rsp_flags, req0_ready, req1_ready);
         else n_pass++;
         tick();
      end
      rsp_ready = 1'b0;
      #1;
      n_checks++;
      if ({rsp_valid, req0_ready, req1_ready} !== 3'b001)
         $display("FAIL bp_regrant: v/r0/r1=%b, need 001", {rsp_valid, req0_ready, req1_ready});
      else n_pass++;
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_flags} !== {1'b1, 1'b1, 5'b11000})
         $display("FAIL bp_div_rsp: v=%b id=%b flg=%b, need 1 1 11000", rsp_valid, rsp_id, rsp_flags);
      else n_pass++;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_stale_done();
      m_manual = 1'b1; m_armed = 1'b0;
      req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'h3F800000; req0_b = 32'h3F800000;
      fpu_done = 1'b1; fpu_result = 32'hDEADBEEF;
      {fpu_NAN, fpu_underflow, fpu_overflow, fpu_zero} = 4'b1000;
      tick();
      req0_valid = 1'b0;
      n_checks++;
      if (fpu_load !== 1'b1) $display("FAIL stale_load: load=%b, need 1", fpu_load);
      else n_pass++;
      tick();
      tick();
      fpu_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({rsp_valid, fpu_enable} !== 2'b01)
            $display("FAIL stale_wait[%0d]: v=%b en=%b, need 0 1", i, rsp_valid, fpu_enable);
         else n_pass++;
         tick();
      end
      fpu_done = 1'b1; fpu_result = 32'h40000000;
      {fpu_NAN, fpu_underflow, fpu_overflow, fpu_zero} = 4'b0000;
      tick();
      fpu_done = 1'b0;
      n_checks++;
      if ({rsp_valid, rsp_result, rsp_flags} !== {1'b1, 32'h40000000, 5'b00000})
         $display("FAIL stale_rsp: v=%b res=%h flg=%b, need 1 40000000 00000", rsp_valid, rsp_result, rsp_flags);
      else n_pass++;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      m_manual = 1'b0;
   endtask

`ifdef FPU_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int lat, ens;
      m_manual = 1'b1; m_armed = 1'b0;
      fpu_done = 1'b0; fpu_result = 32'h12345678;
      req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'h3F800000; req0_b = 32'h3F800000;
      tick();
      req0_valid = 1'b0;
      lat = 1; ens = int'(fpu_enable);
      while (!rsp_valid && lat < 40) begin
         tick();
         lat++;
         ens += int'(fpu_enable);
      end
      n_checks++;
      if (ens !== 16 || lat !== 18)
         $display("FAIL tmo_run_len: enables=%0d latency=%0d, need 16 18", ens, lat);
      else n_pass++;
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_flags, fpu_enable} !== {1'b1, 1'b0, 32'h0, 5'b10000, 1'b0})
         $display("FAIL tmo_rsp: v=%b id=%b res=%h flg=%b en=%b, need 1 0 00000000 10000 0",
                  rsp_valid, rsp_id, rsp_result, rsp_flags, fpu_enable);
      else n_pass++;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      m_manual = 1'b0;
   endtask
`endif

   task automatic test_reset_mid_run();
      logic seen;
      m_manual = 1'b1; m_armed = 1'b0;
      fpu_done = 1'b0;
      req0_valid = 1'b1; req0_op = 2'b10; req0_a = 32'h40400000; req0_b = 32'h40400000;
      tick();
      req0_valid = 1'b0;
      tick();
      tick();
      n_checks++;
      if (fpu_enable !== 1'b1) $display("FAIL midrst_running: en=%b, need 1", fpu_enable);
      else n_pass++;
      rst = 1'b1;
      tick();
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_flags, fpu_load, fpu_enable, fpu_op, fpu_a, fpu_b} !== '0)
         $display("FAIL midrst_outputs: v=%b id=%b res=%h flg=%b load=%b en=%b op=%b a=%h b=%h, need all 0",
                  rsp_valid, rsp_id, rsp_result, rsp_flags, fpu_load, fpu_enable, fpu_op, fpu_a, fpu_b);
      else n_pass++;
      rst = 1'b0;
      fpu_done = 1'b1; fpu_result = 32'h40000000;
      seen = 1'b0;
      repeat (8) begin
         tick();
         if (rsp_valid || fpu_enable || fpu_load) seen = 1'b1;
      end
      fpu_done = 1'b0;
      n_checks++;
      if (seen !== 1'b0) $display("FAIL midrst_dropped: activity seen after reset, need none");
      else n_pass++;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b10)
         $display("FAIL midrst_pointer: got %b, need 10", {req0_ready, req1_ready});
      else n_pass++;
      req0_valid = 1'b0; req1_valid = 1'b0;
      m_manual = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_rr_mul();
      test_add();
      test_div();
      test_back_to_back();
      test_stale_done();
`ifdef FPU_ARB_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_run();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Two-requester front end for the shared floating-point unit: accepts operations, grants the FPU round-robin, sequences its load/enable/done protocol, and returns the result and flags on one response port tagged with the requester id.
- Sits between client blocks and a single fpu instance. Guarantees exactly one operation in flight and stable operands while it executes.

Parameters:
- Mantissa_Size, 23, mantissa width of operands.
- Exponent_Size, 8, exponent width of operands.
- N, Mantissa_Size+Exponent_Size, index of the MSB; data width is N+1.
- TIMEOUT_CYCLES, 64, maximum RUN cycles before abort (only used with FPU_ARB_TIMEOUT_EN); must be at least 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester has an operation.
- req0_ready / req1_ready  out  1  operation accepted this cycle.
- req0_op / req1_op  in  2  00 add, 01 sub, 10 mul, 11 div.
- req0_a, req0_b / req1_a, req1_b  in  N+1  operands.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  N+1  result word.
- rsp_flags  out  5  {err, NAN, underflow, overflow, zero}.
- fpu_load  out  1  one-cycle operand load strobe.
- fpu_enable  out  1  run enable.
- fpu_op  out  2  latched op.
- fpu_a, fpu_b  out  N+1  latched operands.
- fpu_done  in  1  FPU completion (level).
- fpu_result  in  N+1  FPU result.
- fpu_zero, fpu_overflow, fpu_underflow, fpu_NAN  in  1  FPU flags.

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, including fpu_op, fpu_a, fpu_b, rsp_result and rsp_flags.
  - Round-robin pointer favours req0.
- States:
  - IDLE: accept a request.
  - LOAD: fpu_load=1, fpu_enable=0, for exactly one cycle.
  - RUN: fpu_enable=1.
  - RESP: rsp_valid=1.
- IDLE, grant:
  - If exactly one reqX_valid is high, grant it.
  - If both are high, grant the one not granted last; after reset req0 wins.
  - reqX_ready is asserted combinationally in the same cycle for the granted requester only. Acceptance is valid&ready.
  - On acceptance, op, a, b and the id are registered onto fpu_op, fpu_a, fpu_b and an internal id register, and the pointer updates.
- IDLE, next state:
  - op=11 (div, unsupported) goes straight to RESP with result 0 and flags err=1, NAN=1. The FPU is not touched.
  - Any other op goes to LOAD.
- Operand handling: sub is passed to the FPU unchanged as op=01. The controller does not alter the sign of b.
- LOAD → RUN unconditionally.
- RUN:
  - fpu_done is ignored in the first RUN cycle (guard against a stale done).
  - From the second RUN cycle, the first cycle with fpu_done=1 captures fpu_result and the four flags into rsp_result/rsp_flags (err=0) and moves to RESP.
  - fpu_enable drops to 0 on leaving RUN.
- RESP:
  - rsp_valid stays high with rsp_id, rsp_result and rsp_flags all stable until rsp_ready.
  - On rsp_valid&rsp_ready, go to IDLE. rsp_valid is 0 the next cycle.
  - No request is accepted before IDLE, so a new grant is possible at the earliest one cycle after the handshake.
- Operand stability: fpu_a, fpu_b and fpu_op are held constant from LOAD until the next acceptance.
- Minimum latency, acceptance to rsp_valid: 3 + FPU done delay cycles; with done seen on the second RUN cycle, rsp_valid rises 4 cycles after acceptance.
- Reset mid-operation (any state): return to IDLE, outputs cleared, the in-flight operation is dropped with no response, and the pointer returns to favouring req0.
- Requester behaviour: a requester that drops valid before ready simply loses arbitration; there is no penalty.

Optional Feature:
- Macro: FPU_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES with no done, go to RESP with result 0 and flags err=1, others 0.
  - fpu_enable is deasserted.
- Undefined: no counter; RUN waits indefinitely, and the err flag is set only for div.

Decomposition:
- Package fpu_pkg holds:
  - op localparams ADD=2'b00, SUB=2'b01, MUL=2'b10, DIV=2'b11.
  - the state encoding.
  - flag bit indices FLG_ZERO=0, FLG_OVF=1, FLG_UNF=2, FLG_NAN=3, FLG_ERR=4.
- One sub-module, fpu_rr_arb2: a two-way round-robin grant with pointer, taking valid0, valid1 and advance, and producing the grant one-hot.

Test Plan:
- Add, FPU model done 5 cycles after load:
  - req0: op=00, a=32'h3F800000, b=32'h40000000.
  - Expect: one-cycle fpu_load, fpu_enable held until done, rsp_valid with id=0, result=32'h40400000, flags=0.
- Both requesters valid in the first cycle after reset, each with a mul:
  - req0 is granted first and req1 second.
  - Responses arrive in order id 0 then id 1.
  - req1_ready stays 0 until IDLE is re-entered.
- Division: req1 op=11.
  - No fpu_load pulse.
  - rsp_valid on the cycle after acceptance with id=1, result=0, flags=5'b11000.
- Backpressure: rsp_ready held low for 3 cycles while req0 and req1 are valid.
  - rsp outputs are held bit-stable.
  - No ready is asserted until the cycle after the handshake.
- Stale done: fpu_done is high during LOAD and the first RUN cycle, then low, then high 4 cycles later. The response is captured only at the later done.
- Reset and timeout:
  - With FPU_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, fpu_done never rises: after 16 RUN cycles, rsp_valid with result 0 and flags=5'b10000.
  - rst asserted for one cycle mid-RUN: all outputs 0 next cycle, and no rsp_valid follows.
